// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control sequencer: opcodes, ALU op codes, FSM states, IR fields.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    // Instruction opcodes (IR[31:27])
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    // ALU operation select codes
    localparam logic [5:0] ALU_ADD = 6'd1;
    localparam logic [5:0] ALU_SUB = 6'd2;
    localparam logic [5:0] ALU_AND = 6'd3;
    localparam logic [5:0] ALU_OR  = 6'd4;
    localparam logic [5:0] ALU_MUL = 6'd8;
    localparam logic [5:0] ALU_DIV = 6'd9;

    // IR field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    // T-state encoding; S_T4S launches a mul/div, S_T4W waits for it
    typedef enum logic [3:0] {
        S_HALT = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T4S  = 4'd6,
        S_T4W  = 4'd7,
        S_T5   = 4'd8,
        S_T6   = 4'd9
    } state_e;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational instruction decode: IR -> ALU op select, mul/div flag, validity, register fields.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module opcode_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] IR,
    output logic [5:0]  op_sel,
    output logic        is_muldiv,
    output logic        is_valid,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [3:0]  rc
);

    // Low IR bits carry no control information for register-register ops
    logic unused_ir_lo;
    assign unused_ir_lo = ^IR[RC_LSB-1:0];

    assign ra = IR[RA_MSB:RA_LSB];
    assign rb = IR[RB_MSB:RB_LSB];
    assign rc = IR[RC_MSB:RC_LSB];

    // Map opcode to ALU operation; anything outside the table is invalid
    always_comb begin
        op_sel    = '0;
        is_muldiv = 1'b0;
        is_valid  = 1'b1;
        case (IR[OPC_MSB:OPC_LSB])
            OP_ADD: op_sel = ALU_ADD;
            OP_SUB: op_sel = ALU_SUB;
            OP_AND: op_sel = ALU_AND;
            OP_OR:  op_sel = ALU_OR;
            OP_MUL: begin
                op_sel    = ALU_MUL;
                is_muldiv = 1'b1;
            end
            OP_DIV: begin
                op_sel    = ALU_DIV;
                is_muldiv = 1'b1;
            end
            default: is_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, execute T3-T6 for ALU, mul and div instructions.
// Latency: ALU op 6 cycles; mul/div 7 cycles plus cycles spent waiting for finished (bounded by MULDIV_TIMEOUT).
// Backpressure: stalls in S_T4W until finished; aborts with sticky timeout_err if it never arrives.
module alu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MULDIV_TIMEOUT = 64
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] IR,
    input  logic        finished,
    output logic        PCout,
    output logic        IRout,
    output logic        RYout,
    output logic        RZLOout,
    output logic        RZHIout,
    output logic        MARout,
    output logic        RHIout,
    output logic        RLOout,
    output logic        RFout,
    output logic        MDRout,
    output logic        PCin,
    output logic        IRin,
    output logic        RYin,
    output logic        RZin,
    output logic        MARin,
    output logic        RHIin,
    output logic        RLOin,
    output logic        RFin,
    output logic        MDRin,
    output logic [4:0]  RFSelect,
    output logic [5:0]  opSelect,
    output logic        start,
    output logic        Read,
    output logic        IncPC,
    output logic        halted,
    output logic        instr_done,
    output logic        timeout_err
);

    localparam int CNT_W = (MULDIV_TIMEOUT > 1) ? $clog2(MULDIV_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
    logic [5:0]       op_sel_q;
    logic             muldiv_q;
    logic [3:0]       rb_q, rc_q;

    logic [5:0] dec_op_sel;
    logic       dec_muldiv, dec_valid;
    logic [3:0] dec_ra, dec_rb, dec_rc;
    logic       wait_expired;
    state_e     boundary;

    opcode_decoder u_dec (
        .IR        (IR),
        .op_sel    (dec_op_sel),
        .is_muldiv (dec_muldiv),
        .is_valid  (dec_valid),
        .ra        (dec_ra),
        .rb        (dec_rb),
        .rc        (dec_rc)
    );

    // finished takes priority over an expiring wait budget
    assign wait_expired = (state_q == S_T4W) && !finished && (cnt_q == CNT_LAST);
    assign boundary     = run ? S_T0 : S_HALT;
    assign timeout_err  = terr_q;

    // State, wait counter, sticky error and IR field latches (fields captured in S_T3)
    always_ff @(posedge Clock) begin
        if (clear) begin
            state_q  <= S_HALT;
            cnt_q    <= '0;
            terr_q   <= 1'b0;
            op_sel_q <= '0;
            muldiv_q <= 1'b0;
            rb_q     <= '0;
            rc_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            if (state_q == S_T3) begin
                op_sel_q <= dec_op_sel;
                muldiv_q <= dec_muldiv;
                rb_q     <= dec_rb;
                rc_q     <= dec_rc;
            end
        end
    end

    // Next-state sequencing, wait counting and timeout detection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        case (state_q)
            S_HALT: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (!dec_valid)      state_d = boundary;
                else if (dec_muldiv) state_d = S_T4S;
                else                 state_d = S_T4;
            end
            S_T4:   state_d = S_T5;
            S_T4S: begin
                cnt_d   = '0;
                state_d = S_T4W;
            end
            S_T4W: begin
                if (finished) begin
                    state_d = S_T5;
                end else if (wait_expired) begin
                    terr_d  = 1'b1;
                    state_d = boundary;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_T5:   state_d = muldiv_q ? S_T6 : boundary;
            S_T6:   state_d = boundary;
            default: state_d = S_HALT;
        endcase
    end

    // Control line decode from the registered state and latched IR fields
    always_comb begin
        PCout      = 1'b0;
        IRout      = 1'b0;
        RYout      = 1'b0;
        RZLOout    = 1'b0;
        RZHIout    = 1'b0;
        MARout     = 1'b0;
        RHIout     = 1'b0;
        RLOout     = 1'b0;
        RFout      = 1'b0;
        MDRout     = 1'b0;
        PCin       = 1'b0;
        IRin       = 1'b0;
        RYin       = 1'b0;
        RZin       = 1'b0;
        MARin      = 1'b0;
        RHIin      = 1'b0;
        RLOin      = 1'b0;
        RFin       = 1'b0;
        MDRin      = 1'b0;
        RFSelect   = '0;
        opSelect   = '0;
        start      = 1'b0;
        Read       = 1'b0;
        IncPC      = 1'b0;
        halted     = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_HALT: halted = 1'b1;
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                RZin  = 1'b1;
            end
            S_T1: begin
                RZLOout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                // IR was loaded at the end of T2, so decode it live here
                if (dec_valid) begin
                    RFSelect = {1'b0, dec_ra};
                    RFout    = 1'b1;
                    RYin     = 1'b1;
                end else begin
                    instr_done = 1'b1;
                end
            end
            S_T4, S_T4S, S_T4W: begin
                RFSelect   = {1'b0, rb_q};
                RFout      = 1'b1;
                opSelect   = op_sel_q;
                RZin       = 1'b1;
                start      = (state_q == S_T4S);
                instr_done = wait_expired;
            end
            S_T5: begin
                RZLOout = 1'b1;
                if (muldiv_q) begin
                    RLOin = 1'b1;
                end else begin
                    RFSelect   = {1'b0, rc_q};
                    RFin       = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_T6: begin
                RZHIout    = 1'b1;
                RHIin      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Randomized bench for alu_control_sequencer against a per-instruction trace model.
// Latency: checks every cycle's full control word.
// Backpressure: drives finished per wait cycle from a chosen ALU delay.
module tb_alu_control_sequencer;

    localparam int TMO = 8;

    typedef struct packed {
        logic       PCout, IRout, RYout, RZLOout, RZHIout, MARout, RHIout, RLOout, RFout, MDRout;
        logic       PCin, IRin, RYin, RZin, MARin, RHIin, RLOin, RFin, MDRin;
        logic [4:0] RFSelect;
        logic [5:0] opSelect;
        logic       start, Read, IncPC, halted, instr_done, timeout_err;
    } out_t;

    logic        clk = 1'b0;
    logic        clear, run, finished;
    logic [31:0] ir_s;
    logic PCout, IRout, RYout, RZLOout, RZHIout, MARout, RHIout, RLOout, RFout, MDRout;
    logic PCin, IRin, RYin, RZin, MARin, RHIin, RLOin, RFin, MDRin;
    logic [4:0] RFSelect;
    logic [5:0] opSelect;
    logic start, Read, IncPC, halted, instr_done, timeout_err;
    out_t obs;

    int  n_chk = 0, n_pass = 0, cycno = 0;
    int  pos, abort_pos;
    bit  aborted;
    bit  terr = 1'b0;

    always #5 clk = ~clk;

    alu_control_sequencer #(.MULDIV_TIMEOUT(TMO)) dut (
        .Clock(clk), .clear(clear), .run(run), .IR(ir_s), .finished(finished),
        .PCout(PCout), .IRout(IRout), .RYout(RYout), .RZLOout(RZLOout), .RZHIout(RZHIout),
        .MARout(MARout), .RHIout(RHIout), .RLOout(RLOout), .RFout(RFout), .MDRout(MDRout),
        .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin), .RHIin(RHIin),
        .RLOin(RLOin), .RFin(RFin), .MDRin(MDRin), .RFSelect(RFSelect), .opSelect(opSelect),
        .start(start), .Read(Read), .IncPC(IncPC), .halted(halted), .instr_done(instr_done),
        .timeout_err(timeout_err)
    );

    assign obs = {PCout, IRout, RYout, RZLOout, RZHIout, MARout, RHIout, RLOout, RFout, MDRout,
                  PCin, IRin, RYin, RZin, MARin, RHIin, RLOin, RFin, MDRin,
                  RFSelect, opSelect, start, Read, IncPC, halted, instr_done, timeout_err};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cycno, got, exp);
    endtask

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] r32();
        return $urandom();
    endfunction

    function automatic out_t blank();
        out_t b;
        b = '0;
        b.timeout_err = terr;
        return b;
    endfunction

    // Instruction set table: validity, mul/div class and ALU code per opcode
    task automatic ref_decode(input logic [4:0] opc, output bit ok, output bit md, output logic [5:0] sel);
        ok = 1'b1; md = 1'b0; sel = '0;
        case (opc)
            5'b00011: sel = 6'd1;
            5'b00100: sel = 6'd2;
            5'b00101: sel = 6'd3;
            5'b00110: sel = 6'd4;
            5'b01111: begin sel = 6'd8; md = 1'b1; end
            5'b10000: begin sel = 6'd9; md = 1'b1; end
            default:  ok = 1'b0;
        endcase
    endtask

    // One clock: drive inputs, check the control word, advance past the edge
    task automatic step(input string tag, input logic [31:0] ir, input bit fin, input bit rn,
                        input bit cl, input out_t e);
        ir_s = ir; finished = fin; run = rn; clear = cl;
        #1;
        chk(tag, 64'(obs), 64'(e));
        @(posedge clk);
        #1;
        cycno++;
    endtask

    // Emit one expected cycle unless an earlier clear already cut the instruction short
    task automatic emit(input string tag, input out_t e, input bit fin, input bit rn, input logic [31:0] ir);
        bit cl;
        if (aborted) return;
        cl = (pos == abort_pos);
        step(tag, ir, fin, rn, cl, e);
        pos++;
        if (cl) begin
            aborted = 1'b1;
            terr    = 1'b0;
        end
    endtask

    task automatic gen_halt(input int n, input bit leave);
        out_t e;
        pos = 0; abort_pos = -1; aborted = 1'b0;
        for (int i = 0; i < n; i++) begin
            e = blank();
            e.halted = 1'b1;
            emit("halt", e, rbit(), (i == n - 1) ? leave : 1'b0, r32());
        end
    endtask

    // Expected trace of one instruction; fdly = wait cycles until finished is seen high
    task automatic gen_instr(input logic [31:0] ir, input int fdly, input bit run_end,
                             input int abort_at, output bit halts);
        out_t e;
        bit ok, md, done, f;
        logic [5:0] sel;
        ref_decode(ir[31:27], ok, md, sel);
        pos = 0; abort_pos = abort_at; aborted = 1'b0;
        e = blank(); e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.RZin = 1;
        emit("t0", e, rbit(), rbit(), r32());
        e = blank(); e.RZLOout = 1; e.PCin = 1; e.Read = 1; e.MDRin = 1;
        emit("t1", e, rbit(), rbit(), r32());
        e = blank(); e.MDRout = 1; e.IRin = 1;
        emit("t2", e, rbit(), rbit(), r32());
        e = blank();
        if (!ok) begin
            e.instr_done = 1;
            emit("t3_invalid", e, rbit(), run_end, ir);
        end else begin
            e.RFSelect = {1'b0, ir[26:23]}; e.RFout = 1; e.RYin = 1;
            emit("t3", e, rbit(), rbit(), ir);
            e = blank(); e.RFSelect = {1'b0, ir[22:19]}; e.RFout = 1; e.opSelect = sel; e.RZin = 1;
            e.start = md;
            emit("t4", e, rbit(), rbit(), r32());
            if (!md) begin
                e = blank(); e.RZLOout = 1; e.RFSelect = {1'b0, ir[18:15]}; e.RFin = 1; e.instr_done = 1;
                emit("t5_alu", e, rbit(), run_end, r32());
            end else begin
                done = 1'b0;
                for (int k = 1; k <= TMO && !done; k++) begin
                    f = (k >= fdly);
                    e = blank(); e.RFSelect = {1'b0, ir[22:19]}; e.RFout = 1; e.opSelect = sel; e.RZin = 1;
                    if (f) begin
                        emit("wait_fin", e, 1'b1, rbit(), r32());
                        done = 1'b1;
                    end else if (k == TMO) begin
                        e.instr_done = 1;
                        emit("wait_timeout", e, 1'b0, run_end, r32());
                        if (!aborted) terr = 1'b1;
                    end else begin
                        emit("wait", e, 1'b0, rbit(), r32());
                    end
                end
                if (done) begin
                    e = blank(); e.RZLOout = 1; e.RLOin = 1;
                    emit("t5_lo", e, rbit(), rbit(), r32());
                    e = blank(); e.RZHIout = 1; e.RHIin = 1; e.instr_done = 1;
                    emit("t6_hi", e, rbit(), run_end, r32());
                end
            end
        end
        halts = aborted || !run_end;
    endtask

    initial begin
        bit hlt;
        logic [31:0] ir, rr;
        logic [4:0] opc;
        int fd, ab;
        logic [4:0] ops [0:5];
        ops[0] = 5'b00011; ops[1] = 5'b00100; ops[2] = 5'b00101;
        ops[3] = 5'b00110; ops[4] = 5'b01111; ops[5] = 5'b10000;

        clear = 1'b1; run = 1'b0; finished = 1'b0; ir_s = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        gen_halt(10, 1'b0);
        gen_halt(1, 1'b1);
        gen_instr(32'h7A28_0000, 3, 1'b1, -1, hlt);          // mul r4,r5, finished 3 cycles after start
        gen_instr(32'h19A2_0000, 1, 1'b1, -1, hlt);          // add
        gen_instr(32'h7A28_0000, 99, 1'b1, -1, hlt);         // mul timeout
        gen_instr(32'h19A2_0000, 1, 1'b1, -1, hlt);          // fetch continues after timeout
        gen_instr(32'h8123_4567, 99, 1'b1, 6, hlt);          // div, clear in second wait cycle
        gen_halt(2, 1'b1);
        gen_instr(32'h7A28_0000, TMO, 1'b1, -1, hlt);        // finished on the timeout cycle wins
        gen_instr(32'h8000_0000, 1, 1'b1, -1, hlt);          // finished already high on entry
        gen_instr(32'hF800_0000, 1, 1'b0, -1, hlt);          // invalid opcode, run low
        gen_halt(2, 1'b1);

        for (int n = 0; n < 80; n++) begin
            rr = $urandom();
            case ($urandom_range(0, 9))
                8:       opc = 5'b11111;
                9:       opc = 5'($urandom_range(0, 31));
                default: opc = ops[$urandom_range(0, 5)];
            endcase
            ir = {opc, rr[26:0]};
            case ($urandom_range(0, 9))
                0, 1, 2: fd = 1;
                3:       fd = TMO;
                4:       fd = 99;
                default: fd = $urandom_range(2, TMO - 1);
            endcase
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : -1;
            gen_instr(ir, fd, $urandom_range(0, 3) != 0, ab, hlt);
            if (hlt) gen_halt($urandom_range(1, 3), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
